// File: rtl/flit_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : flit_deserializer
// Description : Assembles UART receive bytes (MSB first) into 128-bit flits,
//               verifies the 16-bit word checksum, presents good flits on a
//               valid/ready output register and reports drops as error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module flit_deserializer #(
    parameter int unsigned TIMEOUT_CYCLES = 17360
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   byte_i,
    input  logic         byte_valid_i,
    output logic [127:0] flit_o,
    output logic         flit_valid_o,
    input  logic         flit_ready_i,
    output logic [31:0]  err_o,
    output logic [7:0]   drop_cnt_o
);

    localparam logic [31:0] c_NO_ERROR            = 32'h0000_0000;
    localparam logic [31:0] c_RX_BUFFER_OVERFLOW  = 32'h0000_0001;
    localparam logic [31:0] c_TX_NOT_REACHABLE    = 32'h0000_0002;
    localparam logic [31:0] c_GENERAL_FATAL_ERROR = 32'h8000_0000;
    // Idle count seen in the cycle that completes TIMEOUT_CYCLES idle cycles
    localparam logic [15:0] c_IDLE_LAST           = 16'(TIMEOUT_CYCLES - 1);

    localparam logic [0:0]  c_IDLE  = 1'b0;
    localparam logic [0:0]  c_CHECK = 1'b1;

    logic [119:0] r_shift;
    logic [3:0]   r_cnt;
    logic [15:0]  r_idle;
    logic [127:0] r_chk;
    logic [0:0]   r_state;
    logic [0:0]   w_state_nxt;
    logic [127:0] r_flit;
    logic         r_flit_valid;
    logic [31:0]  r_err;
    logic [7:0]   r_drop;

    logic         w_capture;
    logic         w_timeout;
    logic         w_chk_pending;
    logic [15:0]  w_sum;
    logic         w_good;
    logic         w_consume;
    logic         w_load;
    logic         w_overflow;
    logic         w_bad;
    logic [1:0]   w_drop_inc;
    logic [8:0]   w_drop_sum;

    assign w_capture     = byte_valid_i && (r_cnt == 4'd15);
    // A strobe always beats the timeout in the same cycle
    assign w_timeout     = !byte_valid_i && (r_cnt != 4'd0) && (r_idle == c_IDLE_LAST);
    // The CHECK state doubles as the pending flag for the check register
    assign w_chk_pending = (r_state == c_CHECK);
    assign w_consume     = r_flit_valid && flit_ready_i;

    // Byte assembly: shift in each strobe, discard the partial flit on timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= 4'd0;
        end else if (byte_valid_i) begin
            r_shift <= {r_shift[111:0], byte_i};
            r_cnt   <= r_cnt + 4'd1;
        end else if (w_timeout) begin
            r_cnt   <= 4'd0;
        end
    end

    // Idle counter: cleared by strobes, runs only while a flit is partial
    always_ff @(posedge clk) begin
        if (rst || byte_valid_i || (r_cnt == 4'd0) || w_timeout) begin
            r_idle <= 16'd0;
        end else begin
            r_idle <= r_idle + 16'd1;
        end
    end

    // Check register: snapshot of the complete flit on the 16th byte
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chk <= '0;
        end else if (w_capture) begin
            r_chk <= {r_shift, byte_i};
        end
    end

    // Checksum: modulo-2^16 sum of the seven upper 16-bit words
    always_comb begin
        w_sum = 16'd0;
        for (int i = 0; i < 7; i++) begin
            w_sum = w_sum + r_chk[127 - 16*i -: 16];
        end
        w_good = (w_sum == r_chk[15:0]);
    end

    // Check-stage state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Check-stage next state and outcome decode
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_overflow  = 1'b0;
        w_bad       = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_capture) w_state_nxt = c_CHECK;
            end
            c_CHECK: begin
                w_state_nxt = w_capture ? c_CHECK : c_IDLE;
                if (!w_good) begin
                    w_bad = 1'b1;
                end else if (!r_flit_valid || flit_ready_i) begin
                    w_load = 1'b1;
                end else begin
                    w_overflow = 1'b1;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Output register: held while valid and not ready
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flit       <= '0;
            r_flit_valid <= 1'b0;
        end else if (w_load && w_chk_pending) begin
            r_flit       <= r_chk;
            r_flit_valid <= 1'b1;
        end else if (w_consume) begin
            r_flit_valid <= 1'b0;
        end
    end

    assign w_drop_inc = {1'b0, w_bad} + {1'b0, w_overflow} + {1'b0, w_timeout};
    assign w_drop_sum = {1'b0, r_drop} + {7'd0, w_drop_inc};

    // Error pulse and saturating drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err  <= c_NO_ERROR;
            r_drop <= 8'd0;
        end else begin
            r_err  <= (w_bad      ? c_GENERAL_FATAL_ERROR : c_NO_ERROR)
                    | (w_overflow ? c_RX_BUFFER_OVERFLOW  : c_NO_ERROR)
                    | (w_timeout  ? c_TX_NOT_REACHABLE    : c_NO_ERROR);
            r_drop <= w_drop_sum[8] ? 8'd255 : w_drop_sum[7:0];
        end
    end

    assign flit_o       = r_flit;
    assign flit_valid_o = r_flit_valid;
    assign err_o        = r_err;
    assign drop_cnt_o   = r_drop;

endmodule
`default_nettype wire
